// File: rtl/eeprom_bist_seq_pkg.sv
// Shared types and helpers for the EEPROM self-test sequencer.
// Covers state and pattern encodings, LFSR taps, the request wait limit and saturating arithmetic.
package eeprom_bist_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_BUSY = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_BUSY = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PAT_INC   = 2'd0,
    PAT_CONST = 2'd1,
    PAT_ALT   = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_e;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 feed bit 0)
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
  localparam logic [19:0] REQ_WAIT_CYC = 20'd16;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, v} + {7'd0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/eeprom_bist_seq_if.sv
// Command/data bundle between the self-test sequencer (master) and the I2C EEPROM driver (slave).
interface eeprom_bist_seq_if;
  logic       iic_pluse;
  logic       iic_w_r;
  logic [7:0] iic_byte_len;
  logic [7:0] iic_addr;
  logic [7:0] iic_data_in;
  logic       iic_busy;
  logic       iic_byte_over;
  logic [7:0] iic_data_out;

  modport master (
    output iic_pluse, iic_w_r, iic_byte_len, iic_addr, iic_data_in,
    input  iic_busy, iic_byte_over, iic_data_out
  );

  modport slave (
    input  iic_pluse, iic_w_r, iic_byte_len, iic_addr, iic_data_in,
    output iic_busy, iic_byte_over, iic_data_out
  );
endinterface

// File: rtl/eeprom_bist_seq_pat_gen.sv
// Test pattern generator: the same instance produces write data and the expected read data.
module eeprom_bist_seq_pat_gen
  import eeprom_bist_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_i,
  input  logic       advance_i,
  input  pat_e       sel_i,
  input  logic [7:0] seed_i,
  output logic [7:0] pat_byte_o
);

  logic [7:0] byte_q, byte_d;

  // Next pattern byte: load has priority, then per-pattern step.
  always_comb begin
    byte_d = byte_q;
    if (load_i) begin
      byte_d = ((sel_i == PAT_LFSR) && (seed_i == 8'h00)) ? 8'h01 : seed_i;
    end else if (advance_i) begin
      case (sel_i)
        PAT_INC:   byte_d = byte_q + 8'd1;
        PAT_CONST: byte_d = byte_q;
        PAT_ALT:   byte_d = ~byte_q;
        PAT_LFSR:  byte_d = lfsr_next(byte_q);
        default:   byte_d = byte_q;
      endcase
    end else begin
      byte_d = byte_q;
    end
  end

  // Pattern byte register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_q <= 8'h00;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign pat_byte_o = byte_q;

endmodule

// File: rtl/eeprom_bist_seq.sv
// EEPROM self-test sequencer: writes one page of pattern data, waits out the write cycle,
// reads it back, compares every byte and reports pass/fail, error count and first bad address.
module eeprom_bist_seq
  import eeprom_bist_seq_pkg::*;
#(
  parameter int unsigned PAGE_LEN    = 8,
  parameter logic [7:0]  START_ADDR  = 8'h00,
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter int unsigned WAIT_CYC    = 250_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [1:0]         pattern_sel_i,
  eeprom_bist_seq_if.master  iic,
  output logic               done_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic [7:0]         err_cnt_o,
  output logic [7:0]         first_err_addr_o,
  output logic               timeout_o
);

  localparam logic [7:0]  PAGE_LEN_B = 8'(PAGE_LEN);
  localparam logic [19:0] WAIT_LAST  = 20'(WAIT_CYC - 1);
  localparam logic [19:0] TO_LAST    = 20'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  pat_e       sel_q, sel_d, sel_s;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d, err_q, err_d, first_q, first_d;
  logic       first_vld_q, first_vld_d, timeout_q, timeout_d;
  logic       pluse_q, pluse_d, w_r_q, w_r_d, done_q, done_d;
  logic       pass_q, pass_d, fail_q, fail_d;
  logic       load_s, in_busy_s, data_byte_s, data_err_s, len_err_s;
  logic [7:0] pat_byte_s, byte_cnt_nx_s;

  assign sel_s         = (state_q == ST_IDLE) ? pat_e'(pattern_sel_i) : sel_q;
  assign in_busy_s     = (state_q == ST_WR_BUSY) || (state_q == ST_RD_BUSY);
  // Byte strobes past PAGE_LEN still count toward the length check but carry no data.
  assign data_byte_s   = in_busy_s && iic.iic_byte_over && (byte_cnt_q < PAGE_LEN_B);
  assign data_err_s    = data_byte_s && (state_q == ST_RD_BUSY) && (iic.iic_data_out != pat_byte_s);
  assign byte_cnt_nx_s = iic.iic_byte_over ? sat_inc8(byte_cnt_q) : byte_cnt_q;
  assign len_err_s     = in_busy_s && !iic.iic_busy && (byte_cnt_nx_s != PAGE_LEN_B);

  eeprom_bist_seq_pat_gen u_pat_gen (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (load_s),
    .advance_i  (data_byte_s),
    .sel_i      (sel_s),
    .seed_i     (SEED),
    .pat_byte_o (pat_byte_s)
  );

  // Sequencer next-state, counters and status.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    byte_cnt_d = byte_cnt_q;
    pluse_d   = 1'b0;
    w_r_d     = w_r_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    load_s    = 1'b0;
    err_d     = sat_add8(err_q, {1'b0, data_err_s} + {1'b0, len_err_s});
    if (data_err_s && !first_vld_q) begin
      first_d     = START_ADDR + byte_cnt_q;
      first_vld_d = 1'b1;
    end else begin
      first_d     = first_q;
      first_vld_d = first_vld_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_WR_REQ;
          sel_d       = pat_e'(pattern_sel_i);
          pluse_d     = 1'b1;
          w_r_d       = 1'b1;
          load_s      = 1'b1;
          cnt_d       = 20'd0;
          byte_cnt_d  = 8'd0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          err_d       = 8'd0;
          first_d     = 8'h00;
          first_vld_d = 1'b0;
          timeout_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (iic.iic_busy) begin
          state_d = (state_q == ST_WR_REQ) ? ST_WR_BUSY : ST_RD_BUSY;
          cnt_d   = 20'd0;
        end else if (cnt_q == REQ_WAIT_CYC) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      ST_WR_BUSY, ST_RD_BUSY: begin
        byte_cnt_d = byte_cnt_nx_s;
        if (!iic.iic_busy) begin
          state_d = (state_q == ST_WR_BUSY) ? ST_WAIT : ST_DONE;
          cnt_d   = 20'd0;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = ST_RD_REQ;
          pluse_d    = 1'b1;
          w_r_d      = 1'b0;
          load_s     = 1'b1;
          cnt_d      = 20'd0;
          byte_cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Result is resolved on entry to DONE so it is valid alongside the done pulse.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      pass_d = (err_d == 8'd0) && !timeout_d;
      fail_d = !((err_d == 8'd0) && !timeout_d);
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      sel_q       <= PAT_INC;
      cnt_q       <= 20'd0;
      byte_cnt_q  <= 8'd0;
      pluse_q     <= 1'b0;
      w_r_q       <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_q       <= 8'd0;
      first_q     <= 8'h00;
      first_vld_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      pluse_q     <= pluse_d;
      w_r_q       <= w_r_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      first_q     <= first_d;
      first_vld_q <= first_vld_d;
      timeout_q   <= timeout_d;
    end
  end

  assign iic.iic_pluse    = pluse_q;
  assign iic.iic_w_r      = w_r_q;
  assign iic.iic_byte_len = PAGE_LEN_B;
  assign iic.iic_addr     = START_ADDR;
  assign iic.iic_data_in  = pat_byte_s;

  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign fail_o           = fail_q;
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = first_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_eeprom_bist_seq.sv
// Directed bench for eeprom_bist_seq with a behavioural iic_dri and a 256-byte EEPROM model.
module tb_eeprom_bist_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [1:0] psel;
  logic       done, pass, fail, timeout;
  logic [7:0] err_cnt, first_err;

  int total = 0;
  int bad   = 0;

  // model state: 0 normal, 1 corrupt addr 03 on read, 2 never busy, 3 short write (7 bytes)
  int         model_mode = 0;
  int         pulse_cnt  = 0;
  int         wcnt       = 0;
  logic [7:0] mem  [0:255];
  logic [7:0] wlog [0:255];

  eeprom_bist_seq_if bus ();

  eeprom_bist_seq #(
    .PAGE_LEN    (8),
    .START_ADDR  (8'h00),
    .SEED        (8'hA5),
    .WAIT_CYC    (100),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start_i          (start),
    .pattern_sel_i    (psel),
    .iic              (bus),
    .done_o           (done),
    .pass_o           (pass),
    .fail_o           (fail),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err),
    .timeout_o        (timeout)
  );

  always #5 clk = ~clk;

  // behavioural iic_dri: one byte strobe every 4 cycles, busy drops 2 cycles after the last
  initial begin
    logic       wr;
    int         nb;
    logic [7:0] a;
    bus.iic_busy      = 1'b0;
    bus.iic_byte_over = 1'b0;
    bus.iic_data_out  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.iic_pluse === 1'b1) begin
        pulse_cnt = pulse_cnt + 1;
        if (model_mode != 2) begin
          wr = bus.iic_w_r;
          nb = (wr && model_mode == 3) ? 7 : 8;
          if (wr) wcnt = 0;
          #1 bus.iic_busy = 1'b1;
          for (int k = 0; k < nb; k++) begin
            repeat (3) @(posedge clk);
            #1;
            a = bus.iic_addr + 8'(k);
            if (wr) begin
              mem[a]  = bus.iic_data_in;
              wlog[k] = bus.iic_data_in;
              wcnt    = wcnt + 1;
            end else begin
              bus.iic_data_out = mem[a] ^ ((model_mode == 1 && a == 8'h03) ? 8'hFF : 8'h00);
            end
            bus.iic_byte_over = 1'b1;
            @(posedge clk);
            #1 bus.iic_byte_over = 1'b0;
          end
          repeat (2) @(posedge clk);
          #1 bus.iic_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench watchdog expired");
  end

  // Starts a test and counts done pulses until 5 cycles after the first one.
  task automatic run_bist(input logic [1:0] sel, input int mid_start,
                          output int n_done, output int lat, output bit expired);
    n_done  = 0;
    lat     = 0;
    expired = 1'b1;
    @(negedge clk);
    psel  = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 4000; n++) begin
      if (done === 1'b1) begin
        n_done = n_done + 1;
        if (lat == 0) lat = n;
      end
      if (lat != 0 && n >= lat + 5) begin
        expired = 1'b0;
        break;
      end
      start = (n == mid_start) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rstn  = 1'b0;
    start = 1'b0;
    psel  = 2'd0;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b%b exp=0000", done, pass, fail, timeout); end
    total++; if (err_cnt !== 8'h00 || first_err !== 8'h00) begin
      bad++; $display("FAIL reset_counts got=%h/%h exp=00/00", err_cnt, first_err); end
    total++; if (bus.iic_pluse !== 1'b0 || bus.iic_w_r !== 1'b1 || bus.iic_data_in !== 8'h00) begin
      bad++; $display("FAIL reset_bus got=%b %b %h exp=0 1 00", bus.iic_pluse, bus.iic_w_r, bus.iic_data_in); end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++; if (bus.iic_pluse !== 1'b0) begin
        bad++; $display("FAIL reset_release_pluse got=%b exp=0", bus.iic_pluse); end
    end
  endtask

  task automatic test_inc;
    int nd, lat, p0; bit exp_to;
    model_mode = 0;
    p0 = pulse_cnt;
    run_bist(2'd0, 0, nd, lat, exp_to);
    total++; if (exp_to || nd != 1) begin
      bad++; $display("FAIL inc_done got=%0d expired=%0d exp=1", nd, exp_to); end
    total++; if (wcnt != 8) begin bad++; $display("FAIL inc_wcnt got=%0d exp=8", wcnt); end
    for (int k = 0; k < 8; k++) begin
      total++; if (wlog[k] !== 8'hA5 + 8'(k)) begin
        bad++; $display("FAIL inc_wdata[%0d] got=%h exp=%h", k, wlog[k], 8'hA5 + 8'(k)); end
    end
    total++; if (pass !== 1'b1 || fail !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL inc_result got=p%b f%b t%b exp=p1 f0 t0", pass, fail, timeout); end
    total++; if (err_cnt !== 8'd0 || first_err !== 8'h00) begin
      bad++; $display("FAIL inc_err got=%h/%h exp=00/00", err_cnt, first_err); end
    total++; if (pulse_cnt - p0 != 2) begin
      bad++; $display("FAIL inc_pulses got=%0d exp=2", pulse_cnt - p0); end
  endtask

  task automatic test_lfsr;
    int nd, lat; bit exp_to; logic [7:0] r;
    model_mode = 0;
    run_bist(2'd3, 0, nd, lat, exp_to);
    total++; if (exp_to || nd != 1) begin
      bad++; $display("FAIL lfsr_done got=%0d expired=%0d exp=1", nd, exp_to); end
    r = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      total++; if (wlog[k] !== r) begin
        bad++; $display("FAIL lfsr_wdata[%0d] got=%h exp=%h", k, wlog[k], r); end
      r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    end
    total++; if (wlog[1] !== 8'h4A || wlog[2] !== 8'h95) begin
      bad++; $display("FAIL lfsr_hand got=%h,%h exp=4a,95", wlog[1], wlog[2]); end
    total++; if (pass !== 1'b1 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL lfsr_result got=p%b e%h exp=p1 e00", pass, err_cnt); end
  endtask

  task automatic test_corrupt;
    int nd, lat; bit exp_to;
    model_mode = 1;
    run_bist(2'd2, 0, nd, lat, exp_to);
    total++; if (exp_to || nd != 1) begin
      bad++; $display("FAIL corrupt_done got=%0d expired=%0d exp=1", nd, exp_to); end
    total++; if (wlog[0] !== 8'hA5 || wlog[1] !== 8'h5A || wlog[7] !== 8'h5A) begin
      bad++; $display("FAIL corrupt_alt got=%h %h %h exp=a5 5a 5a", wlog[0], wlog[1], wlog[7]); end
    total++; if (fail !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL corrupt_result got=p%b f%b t%b exp=p0 f1 t0", pass, fail, timeout); end
    total++; if (err_cnt !== 8'd1 || first_err !== 8'h03) begin
      bad++; $display("FAIL corrupt_err got=%h/%h exp=01/03", err_cnt, first_err); end
  endtask

  task automatic test_no_busy;
    int nd, lat, p0; bit exp_to;
    model_mode = 2;
    p0 = pulse_cnt;
    run_bist(2'd0, 0, nd, lat, exp_to);
    total++; if (exp_to || nd != 1) begin
      bad++; $display("FAIL nobusy_done got=%0d expired=%0d exp=1", nd, exp_to); end
    total++; if (lat < 17 || lat > 19) begin
      bad++; $display("FAIL nobusy_latency got=%0d exp=17..19", lat); end
    total++; if (timeout !== 1'b1 || fail !== 1'b1 || pass !== 1'b0) begin
      bad++; $display("FAIL nobusy_result got=t%b f%b p%b exp=t1 f1 p0", timeout, fail, pass); end
    total++; if (pulse_cnt - p0 != 1) begin
      bad++; $display("FAIL nobusy_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_short_write;
    int nd, lat, p0; bit exp_to;
    model_mode = 3;
    p0 = pulse_cnt;
    run_bist(2'd1, 50, nd, lat, exp_to);
    total++; if (exp_to || nd != 1) begin
      bad++; $display("FAIL short_done got=%0d expired=%0d exp=1", nd, exp_to); end
    total++; if (wcnt != 7 || wlog[6] !== 8'hA5) begin
      bad++; $display("FAIL short_wdata got=%0d/%h exp=7/a5", wcnt, wlog[6]); end
    // 1 length error + byte 7 still holds 5A from the alternating run
    total++; if (fail !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL short_result got=p%b f%b t%b exp=p0 f1 t0", pass, fail, timeout); end
    total++; if (err_cnt !== 8'd2 || first_err !== 8'h07) begin
      bad++; $display("FAIL short_err got=%h/%h exp=02/07", err_cnt, first_err); end
    total++; if (pulse_cnt - p0 != 2) begin
      bad++; $display("FAIL short_pulses got=%0d exp=2", pulse_cnt - p0); end
  endtask

  task automatic test_reset_mid_read;
    int nd, lat; bit exp_to, found;
    model_mode = 0;
    @(negedge clk);
    psel  = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.iic_busy === 1'b1 && bus.iic_w_r === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL midrd_reach got=0 exp=1"); end
    repeat (6) @(negedge clk);
    total++; if (bus.iic_data_in === 8'h00) begin
      bad++; $display("FAIL midrd_pre got=%h exp=nonzero", bus.iic_data_in); end
    #3 rstn = 1'b0;
    #1;
    total++; if (bus.iic_w_r !== 1'b1 || bus.iic_data_in !== 8'h00 || bus.iic_pluse !== 1'b0) begin
      bad++; $display("FAIL midrd_async_bus got=%b %h %b exp=1 00 0", bus.iic_w_r, bus.iic_data_in, bus.iic_pluse); end
    total++; if (done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || timeout !== 1'b0 || err_cnt !== 8'h00) begin
      bad++; $display("FAIL midrd_async_status got=%b%b%b%b %h exp=0000 00", done, pass, fail, timeout, err_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (bus.iic_pluse !== 1'b0) begin
        bad++; $display("FAIL midrd_release_pluse got=%b exp=0", bus.iic_pluse); end
    end
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.iic_busy === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL midrd_model_idle got=0 exp=1"); end
    run_bist(2'd0, 0, nd, lat, exp_to);
    total++; if (exp_to || nd != 1) begin
      bad++; $display("FAIL midrd_rerun_done got=%0d expired=%0d exp=1", nd, exp_to); end
    total++; if (pass !== 1'b1 || fail !== 1'b0 || err_cnt !== 8'd0 || wlog[7] !== 8'hAC) begin
      bad++; $display("FAIL midrd_rerun got=p%b f%b e%h w7=%h exp=p1 f0 e00 w7=ac", pass, fail, err_cnt, wlog[7]); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_lfsr();
    test_corrupt();
    test_no_busy();
    test_short_write();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
